// File: rtl/spart_tx_arbiter_if.sv
// Requester handshakes and the bus-side write strobe of the shared SPART transmitter.
// The slave modport is the arbiter view; master is the requesters/transmitter view.
interface spart_tx_arbiter_if;
  logic       req0;
  logic [7:0] data0;
  logic       ack0;
  logic       req1;
  logic [7:0] data1;
  logic       ack1;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] tx_byte;
  logic       busy;
  logic       tmo_err;

  modport master (
    output req0, data0, req1, data1, tbr,
    input  ack0, ack1, iocs, iorw, ioaddr, tx_byte, busy, tmo_err
  );

  modport slave (
    input  req0, data0, req1, data1, tbr,
    output ack0, ack1, iocs, iorw, ioaddr, tx_byte, busy, tmo_err
  );
endinterface

// File: rtl/spart_tx_arbiter.sv
// Round-robin arbiter sharing one SPART transmitter between a processor port (0)
// and a debug port (1); keeps exactly one byte in flight by following tbr.
module spart_tx_arbiter #(
  parameter int               TMO_W   = 8,
  parameter logic [TMO_W-1:0] TMO_MAX = TMO_W'(16)
) (
  input  logic               clk,
  input  logic               rst,
  spart_tx_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } state_t;

  state_t           state_r;
  logic             last_grant_r;
  logic [TMO_W-1:0] wdog_r;
  logic             ack0_r;
  logic             ack1_r;
  logic             iocs_r;
  logic             iorw_r;
  logic [1:0]       ioaddr_r;
  logic [7:0]       tx_byte_r;
  logic             busy_r;
  logic             tmo_err_r;

  logic             grant_valid_s;
  logic             grant_port_s;
  logic [7:0]       grant_data_s;

  // Grant selection: a lone requester wins, contention goes to the port not served last.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_port_s  = 1'b0;
    if (bus.req0 && bus.req1) begin
      grant_valid_s = 1'b1;
      grant_port_s  = ~last_grant_r;
    end else if (bus.req0) begin
      grant_valid_s = 1'b1;
      grant_port_s  = 1'b0;
    end else if (bus.req1) begin
      grant_valid_s = 1'b1;
      grant_port_s  = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_port_s  = 1'b0;
    end
    grant_data_s = grant_port_s ? bus.data1 : bus.data0;
  end

  // Arbitration FSM with all transmitter-facing outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      wdog_r       <= '0;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      iocs_r       <= 1'b0;
      iorw_r       <= 1'b1;
      ioaddr_r     <= 2'b00;
      tx_byte_r    <= 8'h00;
      busy_r       <= 1'b0;
      tmo_err_r    <= 1'b0;
    end else begin
      // The write strobe and acks are high only for the single ISSUE cycle.
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      iocs_r   <= 1'b0;
      iorw_r   <= 1'b1;
      ioaddr_r <= 2'b00;
      case (state_r)
        IDLE: begin
          if (bus.tbr && grant_valid_s) begin
            state_r      <= ISSUE;
            tx_byte_r    <= grant_data_s;
            last_grant_r <= grant_port_s;
            iocs_r       <= 1'b1;
            iorw_r       <= 1'b0;
            ack0_r       <= ~grant_port_s;
            ack1_r       <= grant_port_s;
            busy_r       <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          wdog_r  <= '0;
          state_r <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!bus.tbr) begin
            state_r <= WAIT_HIGH;
          end else if (wdog_r == (TMO_MAX - TMO_W'(1))) begin
            // Transmitter never took the byte; it is dropped but already acked.
            tmo_err_r <= 1'b1;
            state_r   <= IDLE;
            busy_r    <= 1'b0;
          end else begin
            wdog_r <= wdog_r + TMO_W'(1);
          end
        end
        WAIT_HIGH: begin
          if (bus.tbr) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= WAIT_HIGH;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack0    = ack0_r;
  assign bus.ack1    = ack1_r;
  assign bus.iocs    = iocs_r;
  assign bus.iorw    = iorw_r;
  assign bus.ioaddr  = ioaddr_r;
  assign bus.tx_byte = tx_byte_r;
  assign bus.busy    = busy_r;
  assign bus.tmo_err = tmo_err_r;

endmodule

// File: doc/spart_tx_arbiter.md
Name: spart_tx_arbiter

Overview:
- Shares the single SPART transmitter between two byte producers: port 0 is the processor path and port 1 is the debug/trace path.
- Arbitrates round-robin and drives the transmitter's bus-side write strobe (iocs/iorw/ioaddr/data).
- Tracks the transmitter's tbr flag through a full byte so that only one byte is ever in flight.
- Sits between the requesters and the transmitter, inside the SPART wrapper.

Parameters:
- TMO_W, 8, width of the tbr-drop watchdog counter.
- TMO_MAX, 8'd16, cycles allowed for tbr to fall after a strobe before the arbiter abandons the byte.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0  in  1  port 0 has a byte; level, held until ack0
- data0  in  8  port 0 byte; stable while req0=1
- ack0  out  1  one-cycle pulse: data0 was issued to the transmitter
- req1  in  1  port 1 has a byte; level, held until ack1
- data1  in  8  port 1 byte; stable while req1=1
- ack1  out  1  one-cycle pulse: data1 was issued
- tbr  in  1  transmitter buffer ready, from the transmitter
- iocs  out  1  chip select to the transmitter
- iorw  out  1  0 = write, to the transmitter
- ioaddr  out  2  register select to the transmitter
- tx_byte  out  8  byte to the transmitter's transmit_buffer
- busy  out  1  a byte is in flight (state != IDLE)
- tmo_err  out  1  sticky: watchdog fired; cleared only by rst

Behaviour:
- Reset values:
  - Outputs: ack0=ack1=0, iocs=0, iorw=1, ioaddr=2'b00, tx_byte=8'h00, busy=0, tmo_err=0.
  - Internal: state=IDLE, last_grant=1, so port 0 wins first.
- All outputs are registered. The reset behaviour applies on any cycle, including mid-byte: the arbiter returns to IDLE, and the transmitter's own reset is responsible for the line.
- States IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
- IDLE:
  - Leaves IDLE when tbr=1 and (req0|req1).
  - Grant selection:
    - Only one requester active: that requester is granted.
    - Both active: the port other than last_grant is granted.
  - On grant:
    - Latch the granted data into tx_byte and set last_grant.
    - Go to ISSUE.
  - If tbr=0, stay in IDLE even with requests pending.
- ISSUE, exactly one cycle:
  - Outputs iocs=1, iorw=0, ioaddr=2'b00.
  - ack of the granted port = 1 in this same cycle.
  - Clear the watchdog. Go to WAIT_LOW.
  - In every other state iocs=0, iorw=1, ioaddr=2'b00, ack=0.
- WAIT_LOW:
  - Waits for the transmitter to accept the byte.
  - tbr=0 goes to WAIT_HIGH.
  - Otherwise the watchdog increments. When it reaches TMO_MAX, set tmo_err=1 and go to IDLE; the byte is dropped and its ack has already been given.
  - tbr falls one cycle after the strobe in a correct system.
- WAIT_HIGH:
  - tbr=1 goes to IDLE.
  - No timeout; a byte at any baud rate may take arbitrarily long.
- busy = (state != IDLE).
- Earliest next grant is the cycle after the return to IDLE. Minimum spacing between strobes is 4 cycles plus the byte time.
- Requester rules:
  - req may drop only after its ack. A req dropped before ack is ignored if the drop occurs in IDLE before the grant.
  - A requester holding req after ack is treated as a new byte.
- Both requesters asserted continuously: grants strictly alternate 0,1,0,1.
- A req arriving during WAIT_* waits. No queueing beyond the held request.

Test Plan:
- Single byte:
  - Stimulus: tbr=1, req0 with data0=8'hA5.
  - Required: ISSUE one cycle later with iocs=1, iorw=0, ioaddr=0, tx_byte=A5 and ack0 in the same cycle.
  - Then model tbr: 0 for 100 cycles, then 1. busy falls one cycle after tbr rises.
- Contention:
  - Stimulus: req0 and req1 both held for 4 bytes (data0=11, data1=22).
  - Required: issue order 11,22,11,22; exactly 4 ack pulses, alternating.
- Not ready:
  - Stimulus: tbr=0, req1 asserted for 20 cycles, then tbr=1.
  - Required: no strobe while tbr=0; strobe 1 cycle after tbr rises; ack1 pulses once.
- Watchdog:
  - Stimulus: tbr stuck at 1 after a strobe.
  - Required: tmo_err=1 after exactly TMO_MAX WAIT_LOW cycles; return to IDLE.
  - A following req0 is still serviced. tmo_err stays 1 until rst.
- Reset mid-byte:
  - Stimulus: assert rst in WAIT_HIGH.
  - Required: next cycle busy=0, iocs=0, tmo_err=0. First grant after reset goes to port 0 when both ports request.
- Integration:
  - Stimulus: connect the actual SPART transmitter and send bytes 8'h55 and 8'h0F back-to-back from port 1.
  - Required: the txd waveform shows two complete frames with no overlap; tbr toggles once per byte.
